uart_tx_fifo: RTL and testbench

- Byte FIFO and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a host-side write strobe, buffers them, and feeds them one at a time into the transmitter's DV/byte inputs.
- Paces each launch from the transmitter's Active/Done outputs, so back-to-back frames go out with no host involvement and no lost bytes.

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host write and transmitter launch signals of the UART TX FIFO
interface uart_tx_fifo_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  i_Wr_DV;
    logic [7:0]            i_Wr_Byte;
    logic                  o_Full;
    logic                  o_Empty;
    logic [ADDR_WIDTH:0]   o_Count;
    logic                  o_Overflow;
    logic                  o_Tx_DV;
    logic [7:0]            o_Tx_Byte;
    logic                  i_Tx_Active;
    logic                  i_Tx_Done;
    logic                  o_Busy;

    // Host writer and transmitter side
    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
    );

    // FIFO side
    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch pacing in front of the UART transmitter
module uart_tx_fifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH:0]    count;
    logic                   full;
    logic                   empty;
    logic                   wr_en;
    logic                   pop;
    logic                   tx_dv_q;
    logic [7:0]             tx_byte_q;
    logic                   overflow_q;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // Full refuses the write even when a pop frees a slot on the same edge
    assign wr_en = bus.i_Wr_DV && !full;

    // Next state; a pop only happens when leaving idle, and only once the
    // transmitter shows neither Active nor its trailing Done
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !bus.i_Tx_Active && !bus.i_Tx_Done) begin
                    state_d = S_LAUNCH;
                    pop     = 1'b1;
                end
            end
            S_LAUNCH:    state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.i_Tx_Done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Storage array; contents are not reset
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[wr_ptr] <= bus.i_Wr_Byte;
    end

    // Pointers, occupancy and registered launch/overflow outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.i_Wr_DV && full;
            tx_dv_q    <= pop;
            if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop) begin
                tx_byte_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.o_Full     = full;
    assign bus.o_Empty    = empty;
    assign bus.o_Count    = count;
    assign bus.o_Overflow = overflow_q;
    assign bus.o_Tx_DV    = tx_dv_q;
    assign bus.o_Tx_Byte  = tx_byte_q;
    assign bus.o_Busy     = !empty || (state_q != S_IDLE) || bus.i_Tx_Active;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo with an Active/Done transmitter model
module tb_uart_tx_fifo;
    localparam int ADDR_WIDTH = 4;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b0;

    uart_tx_fifo_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    uart_tx_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int errors = 0;

    // transmitter model state and launch log
    int         cyc = 0;
    bit         force_active = 1'b0;
    int         active_len = 20;
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    int         act_left = 0;
    int         done_left = 0;
    bit         prev_dv = 1'b0;
    int         dv_violation = 0;
    int         dv_double = 0;
    logic [7:0] dv_bytes[$];
    int         dv_cycles[$];
    int         done_cycles[$];

    // Transmitter model: Active for active_len cycles after each DV, then Done for 2
    initial begin
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        forever begin
            @(posedge i_Clock);
            #1;
            cyc++;
            if (bus.o_Tx_DV === 1'b1) begin
                dv_bytes.push_back(bus.o_Tx_Byte);
                dv_cycles.push_back(cyc);
                if (bus.i_Tx_Active || bus.i_Tx_Done) dv_violation++;
                if (prev_dv) dv_double++;
                m_active = 1'b1;
                act_left = active_len;
            end else if (m_active) begin
                if (act_left <= 1) begin
                    m_active  = 1'b0;
                    m_done    = 1'b1;
                    done_left = 2;
                    done_cycles.push_back(cyc);
                end else begin
                    act_left--;
                end
            end else if (m_done) begin
                if (done_left <= 1) m_done = 1'b0;
                else                done_left--;
            end
            prev_dv = (bus.o_Tx_DV === 1'b1);
            bus.i_Tx_Active = force_active || m_active;
            bus.i_Tx_Done   = m_done;
        end
    end

    task automatic step();
        @(posedge i_Clock);
        #2;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((bus.o_Busy || bus.i_Tx_Done || bus.o_Count != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic test_reset();
        bus.i_Wr_DV = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        #2;
        i_Reset = 1'b1;
        #1;
        checks++; if (bus.o_Tx_DV !== 1'b0) begin errors++; $display("FAIL reset_tx_dv: got %b expected 0", bus.o_Tx_DV); end
        checks++; if (bus.o_Tx_Byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h expected 00", bus.o_Tx_Byte); end
        checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.o_Overflow); end
        checks++; if (bus.o_Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.o_Full); end
        checks++; if (bus.o_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.o_Empty); end
        checks++; if (bus.o_Count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.o_Count); end
        checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_Busy); end
        step();
        step();
        i_Reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        int base;
        base = dv_bytes.size();
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Byte = 8'hA5;
        step();
        bus.i_Wr_DV = 1'b0;
        checks++; if (bus.o_Count !== 5'd1) begin errors++; $display("FAIL single_count_after_write: got %0d expected 1", bus.o_Count); end
        checks++; if (bus.o_Tx_DV !== 1'b0) begin errors++; $display("FAIL single_dv_early: got %b expected 0", bus.o_Tx_DV); end
        step();
        checks++; if (bus.o_Tx_DV !== 1'b1 || bus.o_Tx_Byte !== 8'hA5) begin errors++; $display("FAIL single_launch: got dv=%b byte=%h expected dv=1 byte=a5", bus.o_Tx_DV, bus.o_Tx_Byte); end
        checks++; if (bus.o_Count !== 5'd0 || bus.o_Empty !== 1'b1) begin errors++; $display("FAIL single_drained: got count=%0d empty=%b expected 0/1", bus.o_Count, bus.o_Empty); end
        step();
        checks++; if (bus.o_Tx_DV !== 1'b0) begin errors++; $display("FAIL single_dv_pulse: got %b expected 0", bus.o_Tx_DV); end
        wait_idle(200, "single");
        checks++; if (dv_bytes.size() - base != 1) begin errors++; $display("FAIL single_dv_count: got %0d expected 1", dv_bytes.size() - base); end
    endtask

    task automatic test_burst();
        int base, dbase, vbase, n, busy_gap;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        active_len = 20;
        base = dv_bytes.size();
        dbase = done_cycles.size();
        vbase = dv_violation;
        for (int i = 0; i < 3; i++) begin
            bus.i_Wr_DV = 1'b1;
            bus.i_Wr_Byte = exp_b[i];
            step();
        end
        bus.i_Wr_DV = 1'b0;
        n = 0;
        busy_gap = 0;
        while (!(dv_bytes.size() - base >= 3 && !bus.o_Busy && !bus.i_Tx_Done) && n < 400) begin
            if (!bus.o_Busy && (dv_bytes.size() - base < 3 || bus.i_Tx_Active)) busy_gap++;
            step();
            n++;
        end
        checks++; if (n >= 400) begin errors++; $display("FAIL burst_timeout: got %0d cycles expected under 400", n); end
        checks++; if (dv_bytes.size() - base != 3) begin errors++; $display("FAIL burst_dv_count: got %0d expected 3", dv_bytes.size() - base); end
        if (dv_bytes.size() - base >= 3 && done_cycles.size() - dbase >= 2) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (dv_bytes[base + i] !== exp_b[i]) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, dv_bytes[base + i], exp_b[i]); end
            end
            checks++; if (dv_cycles[base + 1] - done_cycles[dbase] != 3) begin errors++; $display("FAIL burst_gap1: got %0d expected 3", dv_cycles[base + 1] - done_cycles[dbase]); end
            checks++; if (dv_cycles[base + 2] - done_cycles[dbase + 1] != 3) begin errors++; $display("FAIL burst_gap2: got %0d expected 3", dv_cycles[base + 2] - done_cycles[dbase + 1]); end
        end
        checks++; if (dv_violation != vbase) begin errors++; $display("FAIL burst_dv_gate: got %0d launches while busy expected 0", dv_violation - vbase); end
        checks++; if (dv_double != 0) begin errors++; $display("FAIL burst_dv_width: got %0d multi-cycle pulses expected 0", dv_double); end
        checks++; if (busy_gap != 0) begin errors++; $display("FAIL burst_busy: got %0d low-busy cycles expected 0", busy_gap); end
    endtask

    task automatic test_fill();
        int base;
        active_len = 4;
        force_active = 1'b1;
        step();
        step();
        base = dv_bytes.size();
        for (int i = 0; i < 17; i++) begin
            bus.i_Wr_DV = 1'b1;
            bus.i_Wr_Byte = 8'(i);
            step();
            if (i == 15) begin
                checks++; if (bus.o_Full !== 1'b1 || bus.o_Count !== 5'd16) begin errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1/16", bus.o_Full, bus.o_Count); end
                checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b expected 0", bus.o_Overflow); end
            end
            if (i == 16) begin
                checks++; if (bus.o_Overflow !== 1'b1 || bus.o_Count !== 5'd16) begin errors++; $display("FAIL fill_overflow: got ovf=%b count=%0d expected 1/16", bus.o_Overflow, bus.o_Count); end
            end
        end
        bus.i_Wr_DV = 1'b0;
        step();
        checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_pulse: got %b expected 0", bus.o_Overflow); end
        checks++; if (dv_bytes.size() != base) begin errors++; $display("FAIL fill_held: got %0d launches expected 0", dv_bytes.size() - base); end
        force_active = 1'b0;
        wait_idle(800, "fill");
        checks++; if (dv_bytes.size() - base != 16) begin errors++; $display("FAIL fill_drain_count: got %0d expected 16", dv_bytes.size() - base); end
        if (dv_bytes.size() - base == 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (dv_bytes[base + i] !== 8'(i)) begin errors++; $display("FAIL fill_drain_byte%0d: got %h expected %h", i, dv_bytes[base + i], 8'(i)); end
            end
        end
    endtask

    task automatic test_simul();
        int base;
        active_len = 4;
        force_active = 1'b1;
        step();
        step();
        base = dv_bytes.size();
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Byte = 8'h77;
        step();
        bus.i_Wr_DV = 1'b0;
        step();
        force_active = 1'b0;
        step();
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Byte = 8'h5A;
        step();
        bus.i_Wr_DV = 1'b0;
        checks++; if (bus.o_Tx_DV !== 1'b1 || bus.o_Tx_Byte !== 8'h77) begin errors++; $display("FAIL simul_launch: got dv=%b byte=%h expected 1/77", bus.o_Tx_DV, bus.o_Tx_Byte); end
        checks++; if (bus.o_Count !== 5'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", bus.o_Count); end
        wait_idle(200, "simul");
        checks++; if (dv_bytes.size() - base != 2) begin errors++; $display("FAIL simul_dv_count: got %0d expected 2", dv_bytes.size() - base); end
        if (dv_bytes.size() - base == 2) begin
            checks++; if (dv_bytes[base + 1] !== 8'h5A) begin errors++; $display("FAIL simul_second_byte: got %h expected 5a", dv_bytes[base + 1]); end
        end
    endtask

    task automatic test_wrap();
        int base, n, max_count, ovf, timeouts, bad, first_bad;
        logic [7:0] exp_v;
        active_len = 6;
        base = dv_bytes.size();
        max_count = 0;
        ovf = 0;
        timeouts = 0;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (bus.o_Full && n < 100) begin
                step();
                n++;
                if (int'(bus.o_Count) > max_count) max_count = int'(bus.o_Count);
                if (bus.o_Overflow) ovf++;
            end
            if (n >= 100) timeouts++;
            bus.i_Wr_DV = 1'b1;
            bus.i_Wr_Byte = 8'(i * 7 + 3);
            step();
            bus.i_Wr_DV = 1'b0;
            if (int'(bus.o_Count) > max_count) max_count = int'(bus.o_Count);
            if (bus.o_Overflow) ovf++;
        end
        wait_idle(1000, "wrap");
        checks++; if (timeouts != 0) begin errors++; $display("FAIL wrap_full_stuck: got %0d timeouts expected 0", timeouts); end
        checks++; if (max_count != 16) begin errors++; $display("FAIL wrap_max_count: got %0d expected 16", max_count); end
        checks++; if (ovf != 0) begin errors++; $display("FAIL wrap_overflow: got %0d expected 0", ovf); end
        checks++; if (dv_bytes.size() - base != 40) begin errors++; $display("FAIL wrap_dv_count: got %0d expected 40", dv_bytes.size() - base); end
        bad = 0;
        first_bad = -1;
        if (dv_bytes.size() - base == 40) begin
            for (int i = 0; i < 40; i++) begin
                exp_v = 8'(i * 7 + 3);
                if (dv_bytes[base + i] !== exp_v) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order: got %0d wrong bytes (first at %0d) expected 0", bad, first_bad); end
    endtask

    task automatic test_reset_mid();
        int base, vbase;
        active_len = 20;
        force_active = 1'b0;
        base = dv_bytes.size();
        vbase = dv_violation;
        for (int i = 0; i < 6; i++) begin
            bus.i_Wr_DV = 1'b1;
            bus.i_Wr_Byte = 8'(8'h40 + i);
            step();
        end
        bus.i_Wr_DV = 1'b0;
        checks++; if (bus.o_Count !== 5'd5) begin errors++; $display("FAIL rmid_queued: got %0d expected 5", bus.o_Count); end
        checks++; if (dv_bytes.size() - base != 1) begin errors++; $display("FAIL rmid_first_launch: got %0d expected 1", dv_bytes.size() - base); end
        step();
        step();
        force_active = 1'b1;
        i_Reset = 1'b1;
        #1;
        checks++; if (bus.o_Count !== 5'd0 || bus.o_Empty !== 1'b1 || bus.o_Full !== 1'b0) begin errors++; $display("FAIL rmid_async_flags: got count=%0d empty=%b full=%b expected 0/1/0", bus.o_Count, bus.o_Empty, bus.o_Full); end
        checks++; if (bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h00 || bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL rmid_async_outputs: got dv=%b byte=%h ovf=%b expected 0/00/0", bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Overflow); end
        step();
        i_Reset = 1'b0;
        step();
        checks++; if (bus.o_Empty !== 1'b1) begin errors++; $display("FAIL rmid_flushed: got empty=%b expected 1", bus.o_Empty); end
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Byte = 8'hC3;
        step();
        bus.i_Wr_DV = 1'b0;
        for (int i = 0; i < 30; i++) step();
        checks++; if (dv_bytes.size() - base != 1) begin errors++; $display("FAIL rmid_held_by_active: got %0d launches expected 1", dv_bytes.size() - base); end
        force_active = 1'b0;
        wait_idle(300, "rmid");
        checks++; if (dv_bytes.size() - base != 2) begin errors++; $display("FAIL rmid_dv_count: got %0d expected 2", dv_bytes.size() - base); end
        if (dv_bytes.size() - base == 2) begin
            checks++; if (dv_bytes[base + 1] !== 8'hC3) begin errors++; $display("FAIL rmid_post_byte: got %h expected c3", dv_bytes[base + 1]); end
        end
        checks++; if (dv_violation != vbase) begin errors++; $display("FAIL rmid_dv_gate: got %0d launches while busy expected 0", dv_violation - vbase); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_fill();
        test_simul();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
